// File: rtl/tank_fill_ctrl.sv
// Multi-pump tank fill controller: synchronised/debounced level probes drive a
// registered Moore FSM with round-robin lead rotation, lag assist and fault handling.
module tank_fill_ctrl #(
    parameter int N_PUMPS      = 2,
    parameter int DEB_CYCLES   = 4,
    parameter int LAG_DELAY    = 16,
    parameter int FILL_TIMEOUT = 64,
    parameter int LW           = $clog2(N_PUMPS)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               I,
    input  logic               S,
    input  logic [N_PUMPS-1:0] en,
    input  logic               fault_clr,
    output logic [N_PUMPS-1:0] B,
    output logic [LW-1:0]      lead_idx,
    output logic               fault
);

    localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int TW = $clog2(FILL_TIMEOUT);
    localparam logic [DW-1:0]      DEB_LAST  = DW'(DEB_CYCLES - 1);
    localparam logic [TW-1:0]      TMO_LAST  = TW'(FILL_TIMEOUT - 1);
    localparam logic [TW-1:0]      LAG_LAST  = TW'(LAG_DELAY - 1);
    localparam logic [TW-1:0]      TMR_ONE   = TW'(1);
    localparam logic [DW-1:0]      DEB_ONE   = DW'(1);
    localparam logic [N_PUMPS-1:0] PUMP0_BIT = N_PUMPS'(1);
    localparam logic [LW-1:0]      LEAD_INIT = LW'(N_PUMPS - 1);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_FILL_LEAD = 2'd1,
        ST_FILL_ALL  = 2'd2,
        ST_FAULT     = 2'd3
    } state_t;

    // Channel 0 is the low probe (I), channel 1 the high probe (S).
    logic [1:0]          sync1_q, sync2_q;
    logic [1:0]          filt_q, filt_d;
    logic [DW-1:0]       deb_cnt_q [2];
    logic [DW-1:0]       deb_cnt_d [2];
    state_t              state_q, state_d;
    logic [TW-1:0]       timer_q, timer_d;
    logic [LW-1:0]       lead_idx_q, lead_idx_d;
    logic [LW-1:0]       last_lead_q, last_lead_d;
    logic [N_PUMPS-1:0]  b_q, b_d;
    logic                fault_q, fault_d;
    logic                i_f_s, s_f_s, incons_s;
    logic [LW-1:0]       next_lead_s;

    // First enabled pump strictly after 'last', wrapping around the pump set.
    function automatic logic [LW-1:0] pick_lead(input logic [N_PUMPS-1:0] en_v,
                                                input logic [LW-1:0] last);
        logic [LW-1:0] res;
        logic [LW-1:0] idx_l;
        logic          found;
        int            idx;
        res   = last;
        found = 1'b0;
        for (int k = 1; k <= N_PUMPS; k++) begin
            idx   = (int'(last) + k) % N_PUMPS;
            idx_l = LW'(idx);
            if (!found && en_v[idx_l]) begin
                res   = idx_l;
                found = 1'b1;
            end
        end
        return res;
    endfunction

    assign i_f_s       = filt_q[0];
    assign s_f_s       = filt_q[1];
    assign incons_s    = s_f_s & ~i_f_s;
    assign next_lead_s = pick_lead(en, last_lead_q);

    // Debounce: accept a synchronised change only after DEB_CYCLES stable samples.
    always_comb begin
        filt_d = filt_q;
        for (int ch = 0; ch < 2; ch++) begin
            deb_cnt_d[ch] = deb_cnt_q[ch];
            if (sync2_q[ch] != filt_q[ch]) begin
                if (deb_cnt_q[ch] == DEB_LAST) begin
                    filt_d[ch]    = sync2_q[ch];
                    deb_cnt_d[ch] = '0;
                end else begin
                    deb_cnt_d[ch] = deb_cnt_q[ch] + DEB_ONE;
                end
            end else begin
                deb_cnt_d[ch] = '0;
            end
        end
    end

    // Next-state, timer, lead selection and Moore outputs derived from the next state.
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        lead_idx_d  = lead_idx_q;
        last_lead_d = last_lead_q;
        b_d         = '0;
        fault_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (incons_s) begin
                    state_d = ST_FAULT;
                end else if (!i_f_s && (|en)) begin
                    state_d     = ST_FILL_LEAD;
                    lead_idx_d  = next_lead_s;
                    last_lead_d = next_lead_s;
                    timer_d     = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FILL_LEAD: begin
                if (incons_s) begin
                    state_d = ST_FAULT;
                end else if (s_f_s) begin
                    state_d = ST_IDLE;
                end else if (timer_q == TMO_LAST) begin
                    state_d = ST_FAULT;
                end else if ((timer_q == LAG_LAST) || !en[lead_idx_q]) begin
                    // Timer keeps counting total fill time across the hand-over.
                    state_d = ST_FILL_ALL;
                    timer_d = timer_q + TMR_ONE;
                end else begin
                    timer_d = timer_q + TMR_ONE;
                end
            end
            ST_FILL_ALL: begin
                if (incons_s) begin
                    state_d = ST_FAULT;
                end else if (s_f_s) begin
                    state_d = ST_IDLE;
                end else if (timer_q == TMO_LAST) begin
                    state_d = ST_FAULT;
                end else if (en == '0) begin
                    state_d = ST_FAULT;
                end else begin
                    timer_d = timer_q + TMR_ONE;
                end
            end
            ST_FAULT: begin
                if (fault_clr && !incons_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_FAULT;
                end
            end
            default: begin
                state_d = ST_FAULT;
            end
        endcase

        case (state_d)
            ST_IDLE:      b_d = '0;
            ST_FILL_LEAD: b_d = PUMP0_BIT << lead_idx_d;
            ST_FILL_ALL:  b_d = en;
            ST_FAULT:     fault_d = 1'b1;
            default:      fault_d = 1'b1;
        endcase
    end

    // All state: synchronisers, debounce, FSM and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q      <= 2'b11;
            sync2_q      <= 2'b11;
            filt_q       <= 2'b11;
            deb_cnt_q[0] <= '0;
            deb_cnt_q[1] <= '0;
            state_q      <= ST_IDLE;
            timer_q      <= '0;
            lead_idx_q   <= '0;
            last_lead_q  <= LEAD_INIT;
            b_q          <= '0;
            fault_q      <= 1'b0;
        end else begin
            sync1_q      <= {S, I};
            sync2_q      <= sync1_q;
            filt_q       <= filt_d;
            deb_cnt_q[0] <= deb_cnt_d[0];
            deb_cnt_q[1] <= deb_cnt_d[1];
            state_q      <= state_d;
            timer_q      <= timer_d;
            lead_idx_q   <= lead_idx_d;
            last_lead_q  <= last_lead_d;
            b_q          <= b_d;
            fault_q      <= fault_d;
        end
    end

    assign B        = b_q;
    assign lead_idx = lead_idx_q;
    assign fault    = fault_q;

endmodule

// File: doc/tank_fill_ctrl.md
Name: tank_fill_ctrl

Overview:
- Clocked, parametrised successor to the two-pump water-tank output logic.
- Sensor inputs are synchronised and debounced.
- Drives N_PUMPS fill pumps from a registered Moore FSM, one state machine and one output set per tank:
  - round-robin lead-pump rotation
  - lag-pump assist on slow fills
  - per-pump enable masking
  - dry-run timeout, sensor-inconsistency fault, and fault clear
- Sits between the tank level probes and the pump contactor drivers.

Parameters:
N_PUMPS, 2, number of pumps; must be at least 2.
DEB_CYCLES, 4, consecutive stable cycles required to accept a sensor change; must be at least 1.
LAG_DELAY, 16, cycles in FILL_LEAD before all enabled pumps run; 1 <= LAG_DELAY < FILL_TIMEOUT.
FILL_TIMEOUT, 64, maximum fill cycles before declaring a dry-run fault.
LW, $clog2(N_PUMPS), width of lead_idx.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous, active-low reset
I  in  1  low-level probe, raw; 1 = water above the low probe
S  in  1  high-level probe, raw; 1 = water above the high probe
en  in  N_PUMPS  pump in-service mask; 1 = pump usable
fault_clr  in  1  fault acknowledge, single-cycle pulse
B  out  N_PUMPS  pump run commands, registered
lead_idx  out  LW  index of the current or most recent lead pump, registered
fault  out  1  fault flag, registered

Behaviour:
Reset (async, rst_n=0):
- B=0, fault=0, state=IDLE, timer=0.
- lead_idx=0; last-lead register = N_PUMPS-1, so the first fill leads with pump 0.
- Debounce counters=0; synchronisers and filtered levels I_f, S_f = 1 (tank assumed full, so no pumping).

Sensor conditioning:
- Each of I and S passes through a 2-flop synchroniser.
- A counter increments while the synchroniser output differs from the filtered value and clears on agreement.
- When the count reaches DEB_CYCLES-1 with the values still differing, the filtered value updates and the counter clears.
- Latency: raw change before edge 1 → filtered change at edge 2+DEB_CYCLES → B change at edge 3+DEB_CYCLES.
- Pulses shorter than DEB_CYCLES cycles at the synchroniser output are ignored.
- inconsistent = S_f & ~I_f.

FSM (states IDLE, FILL_LEAD, FILL_ALL, FAULT). Conditions are evaluated in the listed priority order each cycle.
- IDLE:
  - inconsistent → FAULT.
  - else if ~I_f and |en → FILL_LEAD. The lead is the first enabled pump found searching upward, with wrap, from last_lead+1. lead_idx and last_lead are loaded with it; timer=0.
  - else if ~I_f and en=0 → remain in IDLE with B=0.
- FILL_LEAD:
  - inconsistent → FAULT.
  - S_f → IDLE.
  - timer==FILL_TIMEOUT-1 → FAULT.
  - timer==LAG_DELAY-1 or en[lead_idx]==0 → FILL_ALL.
  - otherwise timer+1.
- FILL_ALL:
  - inconsistent → FAULT.
  - S_f → IDLE.
  - timer==FILL_TIMEOUT-1 → FAULT.
  - en=0 → FAULT.
  - otherwise timer+1; timer is not reset on entry.
- FAULT:
  - fault_clr & ~inconsistent → IDLE.
  - fault_clr while inconsistent is ignored.

Hysteresis:
- Filling starts only on ~I_f and stops only on S_f.
- Between the probes (I_f=1, S_f=0), the current state holds.

Outputs:
- Registered from next-state, so they change on the same edge as the state.
- IDLE and FAULT: B=0.
- FILL_LEAD: B = one-hot(lead_idx).
- FILL_ALL: B = en, updated every cycle while in FILL_ALL.
- fault=1 exactly while in FAULT.

Timer:
- Width $clog2(FILL_TIMEOUT).
- Never wraps; the FILL_TIMEOUT-1 compare always fires first.

fault_clr in a non-FAULT state: no effect.

Test Plan:
- Reset, DEB_CYCLES=4, I=S=1, then I→0 before edge 1 → B=01 and lead_idx=0 at edge 7. Then S→1 (I=1) → B=00 at edge 2+4+1 after the change.
- Rotation, N_PUMPS=4, en=1111, three complete fill cycles → lead_idx 0,1,2. Then en=1101 → next leads are 3, then 0, then 2 (pump 1 skipped).
- Lag, LAG_DELAY=16, en=0111, fill started with I=0, S held 0 → B one-hot for 16 cycles, then B=0111; clearing en[lead] mid-FILL_LEAD forces FILL_ALL on the next edge.
- Timeout, FILL_TIMEOUT=64, S held 0 → B=0 and fault=1 at the 64th fill cycle. fault_clr with I=S=1 → IDLE and fault=0 next edge.
- Glitch/fault paths:
  - I low for 3 cycles with DEB=4 → B stays 0.
  - S=1, I=0 stable → fault=1 and B=0.
  - fault_clr while still inconsistent → fault stays 1.
- Async reset mid-fill (B=0010) → B=0, fault=0, lead_idx=0 immediately, without a clock edge.
